// File: rtl/fm_sample_feed_pkg.sv
// Shared definitions for the FM sample feeder: FSM encoding, default rates
// and the sample-to-phase-increment mapping.
package fm_sample_feed_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feed_state_t;

    localparam int          sample_w        = 8;
    localparam logic [31:0] default_carrier = 32'h8555_5555;
    localparam int          default_div     = 4000;

    // Sign-extend, scale by 2^shift, add to the carrier; wraps modulo 2^32.
    function automatic logic [31:0] sample_to_inc(input logic [31:0] carrier,
                                                  input logic [sample_w-1:0] sample,
                                                  input int shift);
        logic [31:0] ext;
        ext = {{(32-sample_w){sample[sample_w-1]}}, sample};
        return carrier + (ext << shift);
    endfunction

endpackage

// File: rtl/fm_sample_feed_if.sv
// Audio sample stream into the feeder.
// Handshake: a sample transfers on a rising edge where i_valid && o_ready;
// the source holds i_data stable while i_valid is high and o_ready is low.
interface fm_sample_feed_if;
    import fm_sample_feed_pkg::*;

    logic [sample_w-1:0] i_data;
    logic                i_valid;
    logic                o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/fm_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when
// empty are ignored.
module fm_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 16,
    localparam int aw = $clog2(p_depth)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               push,
    input  logic               pop,
    input  logic [p_width-1:0] wdata,
    output logic [p_width-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [aw:0]        level
);

    logic [p_width-1:0] mem [p_depth];
    logic [aw-1:0]      wr_ptr;
    logic [aw-1:0]      rd_ptr;
    logic [aw:0]        cnt;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (cnt == (aw+1)'(p_depth));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fm_sample_feed.sv
// Buffers audio samples and, once per sample tick, converts the head sample
// into an NCO phase increment; falls back to the bare carrier on underrun.
module fm_sample_feed
    import fm_sample_feed_pkg::*;
#(
    parameter int          p_depth   = 16,
    parameter int          p_div     = default_div,
    parameter logic [31:0] p_carrier = default_carrier,
    parameter int          p_shift   = 13,
    localparam int lw = $clog2(p_depth) + 1,
    localparam int cw = $clog2(p_div)
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    fm_sample_feed_if.slave         s_in,
    output logic [31:0]             o_inc,
    output logic                    o_strobe,
    output logic                    o_underrun,
    output logic [lw-1:0]           o_level,
    output feed_state_t             o_state
);

    feed_state_t         state, state_nxt;
    logic [cw-1:0]       count, count_nxt;
    logic [31:0]         inc_nxt;
    logic                strobe_nxt;
    logic                underrun_nxt;
    logic                tick;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [sample_w-1:0] head;

    assign tick        = (count == cw'(p_div - 1));
    assign push        = s_in.i_valid && !full;
    assign pop         = tick && (state == RUN) && !empty;
    // Ready comes from registered occupancy only, never from this cycle's pop.
    assign s_in.o_ready = !full;
    assign o_state     = state;

    fm_fifo #(
        .p_width (sample_w),
        .p_depth (p_depth)
    ) u_fifo (
        .clk   (i_clk),
        .nrst  (i_nrst),
        .push  (push),
        .pop   (pop),
        .wdata (s_in.i_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );

    always_comb begin
        state_nxt    = state;
        inc_nxt      = o_inc;
        strobe_nxt   = 1'b0;
        underrun_nxt = 1'b0;
        count_nxt    = tick ? '0 : count + 1'b1;
        case (state)
            FILL: begin
                if (tick) begin
                    inc_nxt    = p_carrier;
                    strobe_nxt = 1'b1;
                end
                if (o_level >= lw'(p_depth / 2)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    strobe_nxt = 1'b1;
                    if (!empty) begin
                        inc_nxt = sample_to_inc(p_carrier, head, p_shift);
                    end else begin
                        inc_nxt      = p_carrier;
                        underrun_nxt = 1'b1;
                        state_nxt    = FILL;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= FILL;
            count      <= '0;
            o_inc      <= p_carrier;
            o_strobe   <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            o_inc      <= inc_nxt;
            o_strobe   <= strobe_nxt;
            o_underrun <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_fm_sample_feed.sv
// Directed plus randomized bench for fm_sample_feed, checked every cycle
// against a queue-based reference model of the feeder's behaviour.
module tb_fm_sample_feed;
    import fm_sample_feed_pkg::*;

    localparam int          depth   = 4;
    localparam int          div     = 8;
    localparam logic [31:0] carrier = 32'h1000_0000;
    localparam int          shift   = 4;
    localparam int          lw      = $clog2(depth) + 1;

    logic              clk = 1'b0;
    logic              nrst;
    logic [31:0]       o_inc;
    logic              o_strobe;
    logic              o_underrun;
    logic [lw-1:0]     o_level;
    feed_state_t       o_state;

    fm_sample_feed_if sif ();

    fm_sample_feed #(
        .p_depth   (depth),
        .p_div     (div),
        .p_carrier (carrier),
        .p_shift   (shift)
    ) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .s_in       (sif),
        .o_inc      (o_inc),
        .o_strobe   (o_strobe),
        .o_underrun (o_underrun),
        .o_level    (o_level),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mq[$];
    int          cyc;
    bit          run;
    logic [31:0] m_inc;
    bit          m_strobe;
    bit          m_under;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("level",    32'(o_level),    32'(mq.size()));
        check("ready",    32'(sif.o_ready), 32'(mq.size() < depth));
        check("inc",      o_inc,           m_inc);
        check("strobe",   32'(o_strobe),   32'(m_strobe));
        check("underrun", 32'(o_underrun), 32'(m_under));
        check("state",    32'(o_state),    32'(run));
    endtask

    // One clock: drive inputs, advance model by one cycle, compare after the edge.
    task automatic step(input bit rst_n, input bit v, input logic [7:0] d, output bit acc);
        bit tick, empty, do_pop, nxt_run;
        int sv;
        nrst        = rst_n;
        sif.i_valid = v;
        sif.i_data  = d;
        acc         = 1'b0;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            mq.delete();
            cyc      = 0;
            run      = 1'b0;
            m_inc    = carrier;
            m_strobe = 1'b0;
            m_under  = 1'b0;
        end else begin
            tick    = (cyc == div - 1);
            empty   = (mq.size() == 0);
            acc     = v && (mq.size() < depth);
            do_pop  = tick && run && !empty;
            nxt_run = run ? !(tick && empty) : (mq.size() >= depth / 2);
            @(posedge clk);
            #1;
            m_strobe = tick;
            m_under  = tick && run && empty;
            if (do_pop) begin
                sv    = $signed(mq.pop_front());
                m_inc = carrier + 32'(sv * (1 << shift));
            end else if (tick) begin
                m_inc = carrier;
            end
            if (acc) mq.push_back(d);
            run = nxt_run;
            cyc = (cyc + 1) % div;
        end
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, acc);
    endtask

    // Hold valid with the same data until the model says it was taken.
    task automatic push_hold(input logic [7:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, 1'b1, d, acc);
            n++;
        end
        if (!acc) check("push_timeout", 32'(o_level), 32'(depth));
    endtask

    initial begin
        bit acc;
        int n;
        int dens;
        nrst        = 1'b0;
        sif.i_valid = 1'b0;
        sif.i_data  = 8'h00;

        step(1'b0, 1'b0, 8'h00, acc);
        step(1'b0, 1'b0, 8'h00, acc);
        idle(40);

        push_hold(8'h01);
        push_hold(8'h02);
        idle(30);

        push_hold(8'h80);
        push_hold(8'h00);
        idle(30);

        for (int i = 0; i < 5; i++) push_hold(8'h10 + 8'(i));

        n = 0;
        while (!(run && mq.size() == 3) && n < 40) begin
            idle(1);
            n++;
        end
        check("reach_level3", 32'(o_level), 32'd3);
        step(1'b0, 1'b1, 8'h55, acc);
        idle(20);

        dens = 2;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) dens = $urandom_range(0, 4);
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) < dens),
                 8'($urandom_range(0, 255)), acc);
        end
        idle(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fm_sample_feed.md
# fm_sample_feed

Upstream feeder for the FM transmitter core, running in the 192 MHz PLL clock domain. It accepts signed 8-bit audio samples over a valid/ready handshake and buffers them in a small FIFO. At a fixed sample rate it releases one sample and converts it to a 32-bit NCO phase increment (carrier plus scaled deviation), which drives the modulator's frequency input. Underruns fall back to the unmodulated carrier and re-enter a prefill phase.

## Interface
- p_depth, 16: FIFO depth in samples; power of two, ≥4
- p_div, 4000: clocks per sample tick (192 MHz / 48 kHz); ≥2
- p_carrier, 32'h8555_5555: carrier phase increment (≈100 MHz alias at 192 MHz)
- p_shift, 13: left shift applied to the sign-extended sample; 0..23
- i_clk  in  1  system clock (PLL output)
- i_nrst  in  1  reset; synchronous, active-low
- i_data  in  8  audio sample, two's complement
- i_valid  in  1  i_data valid
- o_ready  out  1  FIFO can accept; transfer occurs when i_valid && o_ready at a rising edge
- o_inc  out  32  phase increment to modulator
- o_strobe  out  1  one-cycle pulse whenever o_inc is (re)loaded at a tick
- o_underrun  out  1  one-cycle pulse: tick in RUN with the FIFO empty
- o_level  out  $clog2(p_depth)+1  current FIFO occupancy

## Operation
- Divider: counter 0..p_div-1, free-running from reset; tick = (count == p_div-1).
- FSM states: FILL, RUN. Reset → FILL.
  - FILL: no pops. On tick, o_inc ← p_carrier, o_strobe pulses. FILL→RUN at any edge where o_level ≥ p_depth/2.
  - RUN: on tick with FIFO non-empty, pop head; o_inc ← p_carrier + (sext32(sample) << p_shift), mod 2^32; o_strobe pulses. On tick with FIFO empty, o_inc ← p_carrier, o_strobe and o_underrun pulse, RUN→FILL.
- o_ready = !full, derived from registered occupancy only (no combinational path from the pop). When full, a push in the same cycle as a pop is not accepted.
- A push and pop in the same cycle on a non-full FIFO: both occur, level unchanged.
- A push landing in the same cycle as a tick with the FIFO empty is not visible to that tick; underrun is reported.
- Negative samples: the sum wraps modulo 2^32; no saturation.
- Reset values: o_inc = p_carrier, o_strobe = 0, o_underrun = 0, o_level = 0, o_ready = 1 after the first reset edge, divider = 0, FIFO pointers = 0. Reset mid-operation discards all buffered samples.

## Timing
- Push → visible in o_level: next edge.
- Tick cycle → o_inc/o_strobe/o_underrun valid: following edge (1-cycle latency); o_inc holds until the next tick.
- o_strobe period in steady state: exactly p_div clocks.
- FILL→RUN decision is registered; the first pop happens at the first tick after entering RUN.
- Critical path: 32-bit add; its operands are registered FIFO read data and a constant.

## Structure
- fm_defs.vh, shared with fm_tx: FSM state encodings (FILL=1'b0, RUN=1'b1), default carrier increment, and default sample divider.
- Sub-module fm_fifo: synchronous FIFO parameterised by width and depth, with push/pop, full/empty, and level. The divider, FSM, and increment arithmetic stay in fm_sample_feed.

## Test plan
Bench parameters: p_depth=4, p_div=8, p_carrier=32'h1000_0000, p_shift=4.
- Reset then idle 40 cycles → o_inc=32'h1000_0000, o_strobe every 8 cycles, o_underrun never asserts, state FILL.
- Push 8'h01 and 8'h02 → RUN. Next ticks give o_inc 32'h1000_0010, then 32'h1000_0020. The following tick gives o_inc=32'h1000_0000 with o_underrun pulsing, state FILL.
- Push 8'h80 (−128) and 8'h00, then tick → o_inc=32'h0FFF_F800.
- Push 5 samples back-to-back with i_valid held → 4 accepted, o_ready=0 from the edge where o_level=4, and the 5th is held until the next pop.
- Full FIFO, i_valid=1 on the tick cycle → pop occurs, push is not accepted that cycle, o_level=3 then 4 on the next edge.
- Drop i_nrst for 1 cycle mid-RUN with o_level=3 → o_level=0, o_inc=p_carrier, state FILL, divider restarts at 0.
